// File: rtl/pbkdf2_hmac_chain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pbkdf2_pkg                                                      |
// | Purpose  : Shared state encoding and HMAC/SHA-256 message constants for    |
// |            the PBKDF2-HMAC-SHA256 iteration controller.                    |
// | Contents : state_t plus its six state codes, pad bytes, SHA padding        |
// |            constants and the width of the zero fill in block 2.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pbkdf2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_INNER_REQ  = 3'd1;
    localparam state_t S_INNER_WAIT = 3'd2;
    localparam state_t S_OUTER_REQ  = 3'd3;
    localparam state_t S_OUTER_WAIT = 3'd4;
    localparam state_t S_DONE       = 3'd5;

    localparam logic [7:0]  IPAD_BYTE    = 8'h36;
    localparam logic [7:0]  OPAD_BYTE    = 8'h5c;
    localparam logic [7:0]  SHA_PAD_BYTE = 8'h80;
    // HMAC message is always 64-byte key block + 32-byte value = 768 bits.
    localparam logic [63:0] MSG_LEN_BITS = 64'd768;
    // 512 - 256 (value) - 8 (0x80 byte) - 64 (length) = 184 zero bits.
    localparam int          ZERO_FILL_W  = 184;

endpackage
`default_nettype wire

// File: rtl/pbkdf2_hmac_chain_msg_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hmac_msg_fmt                                                    |
// | Purpose  : Combinational builder of the two-block 1024-bit HMAC message   |
// |            fed to the SHA-256 hasher.                                      |
// | Ports    : key_i    512-bit padded key block                               |
// |            u_i      256-bit value hashed under the key                     |
// |            outer_i  0 = inner (ipad), 1 = outer (opad)                     |
// |            msg_o    1024-bit message, block 1 in [1023:512]                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hmac_msg_fmt
    import pbkdf2_pkg::*;
(
    input  logic [511:0]  key_i,
    input  logic [255:0]  u_i,
    input  logic          outer_i,
    output logic [1023:0] msg_o
);

    logic [7:0]   w_pad_byte;
    logic [511:0] w_block1;
    logic [511:0] w_block2;

    assign w_pad_byte = outer_i ? OPAD_BYTE : IPAD_BYTE;
    assign w_block1   = key_i ^ {64{w_pad_byte}};
    // Second block already carries the SHA-256 padding for a 768-bit message.
    assign w_block2   = {u_i, SHA_PAD_BYTE, {ZERO_FILL_W{1'b0}}, MSG_LEN_BITS};
    assign msg_o      = {w_block1, w_block2};

endmodule
`default_nettype wire

// File: rtl/pbkdf2_hmac_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pbkdf2_hmac_chain                                               |
// | Purpose  : PBKDF2-HMAC-SHA256 iteration controller. Chains U(j)->U(j+1)   |
// |            through an external two-block SHA-256 hasher and accumulates   |
// |            T = U1 ^ U2 ^ ... ^ Uc.                                         |
// | Ports    : job_*      job offer (key block, U1, iteration count)           |
// |            hash_in_*  message handshake towards the hasher                 |
// |            hash_out_* digest handshake from the hasher                     |
// |            res_*      result handshake (T)                                 |
// |            busy_o     controller not idle                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pbkdf2_hmac_chain
    import pbkdf2_pkg::*;
#(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [511:0]      job_key_i,
    input  logic [255:0]      job_u1_i,
    input  logic [ITER_W-1:0] job_iter_i,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    output logic [1023:0]     hash_in_o,
    output logic              hash_in_valid_o,
    input  logic              hash_in_ready_i,
    input  logic [255:0]      hash_out_i,
    input  logic              hash_out_valid_i,
    output logic              hash_out_ready_o,
    output logic [255:0]      res_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              busy_o
);

    state_t            state_q, state_d;
    logic [511:0]      key_q,   key_d;
    logic [255:0]      u_q,     u_d;
    logic [255:0]      t_q,     t_d;
    logic [ITER_W-1:0] rem_q,   rem_d;

    logic [ITER_W-1:0] w_job_rem;
    logic              w_req;
    logic [1023:0]     w_msg;

    // Remaining iterations after U1; a count of 0 behaves like 1.
    assign w_job_rem = (job_iter_i == '0) ? '0 : (job_iter_i - ITER_W'(1));

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        u_d     = u_q;
        t_d     = t_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    key_d   = job_key_i;
                    u_d     = job_u1_i;
                    t_d     = job_u1_i;
                    rem_d   = w_job_rem;
                    state_d = (w_job_rem == '0) ? S_DONE : S_INNER_REQ;
                end
            end
            S_INNER_REQ: begin
                if (hash_in_ready_i) begin
                    state_d = S_INNER_WAIT;
                end
            end
            S_INNER_WAIT: begin
                if (hash_out_valid_i) begin
                    u_d     = hash_out_i;
                    state_d = S_OUTER_REQ;
                end
            end
            S_OUTER_REQ: begin
                if (hash_in_ready_i) begin
                    state_d = S_OUTER_WAIT;
                end
            end
            S_OUTER_WAIT: begin
                if (hash_out_valid_i) begin
                    u_d     = hash_out_i;
                    t_d     = t_q ^ hash_out_i;
                    // rem_q >= 1 here, so the decrement cannot wrap.
                    rem_d   = rem_q - ITER_W'(1);
                    state_d = (rem_q == ITER_W'(1)) ? S_DONE : S_INNER_REQ;
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            u_q     <= '0;
            t_q     <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            u_q     <= u_d;
            t_q     <= t_d;
            rem_q   <= rem_d;
        end
    end

    hmac_msg_fmt u_msg_fmt (
        .key_i   (key_q),
        .u_i     (u_q),
        .outer_i (state_q == S_OUTER_REQ),
        .msg_o   (w_msg)
    );

    // Message only leaves the block while it is actually offered; registered
    // operands keep it stable across hasher back-pressure.
    assign w_req            = (state_q == S_INNER_REQ) || (state_q == S_OUTER_REQ);
    assign hash_in_valid_o  = w_req;
    assign hash_in_o        = w_req ? w_msg : '0;
    assign hash_out_ready_o = (state_q == S_INNER_WAIT) || (state_q == S_OUTER_WAIT);
    assign job_ready_o      = (state_q == S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign res_valid_o      = (state_q == S_DONE);
    assign res_o            = (state_q == S_DONE) ? t_q : '0;

endmodule
`default_nettype wire
